// File: rtl/seg_pkg_ysyx_23060136.sv
// Shared types and constants for the pipeline segment register.
package seg_pkg_ysyx_23060136;

    // Holding state of a segment register: nothing, one entry, two entries.
    typedef enum logic [1:0] {
        SEG_EMPTY = 2'd0,
        SEG_FULL  = 2'd1,
        SEG_SKID  = 2'd2
    } seg_state_e;

    localparam int SEG_OCC_W = 2;

    // Number of valid entries held in a given state.
    function automatic logic [SEG_OCC_W-1:0] seg_occ(input seg_state_e st);
        case (st)
            SEG_FULL: seg_occ = SEG_OCC_W'(1);
            SEG_SKID: seg_occ = SEG_OCC_W'(2);
            default:  seg_occ = SEG_OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/seg_skid_reg_ysyx_23060136_sat_cnt.sv
// Saturating event counter; sticks at all-ones and clears only on reset.
module sat_cnt_ysyx_23060136
    import seg_pkg_ysyx_23060136::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count one per event cycle until every bit is set, then hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seg_skid_reg_ysyx_23060136.sv
// Valid/ready pipeline segment register with optional two-entry skid buffer,
// flush, and a saturating back-pressure counter.
module seg_skid_reg_ysyx_23060136
    import seg_pkg_ysyx_23060136::*;
#(
    parameter int                DATA_W  = 128,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter bit                SKID    = 1'b1,
    parameter int                CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [SEG_OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    generate
        if (SKID) begin : g_skid
            seg_state_e        state_q;
            seg_state_e        state_d;
            logic [DATA_W-1:0] main_p0;
            logic [DATA_W-1:0] skid_p1;
            logic [DATA_W-1:0] main_d;
            logic [DATA_W-1:0] skid_d;

            // Next state and register loads; flush overrides every transition.
            always_comb begin
                state_d = state_q;
                main_d  = main_p0;
                skid_d  = skid_p1;
                case (state_q)
                    SEG_EMPTY: begin
                        if (in_fire) begin
                            main_d  = in_data;
                            state_d = SEG_FULL;
                        end
                    end
                    SEG_FULL: begin
                        if (in_fire && out_fire) begin
                            main_d = in_data;
                        end else if (in_fire) begin
                            skid_d  = in_data;
                            state_d = SEG_SKID;
                        end else if (out_fire) begin
                            state_d = SEG_EMPTY;
                        end
                    end
                    SEG_SKID: begin
                        // in_ready is low here, so only the output can move.
                        if (out_fire) begin
                            main_d  = skid_p1;
                            state_d = SEG_FULL;
                        end
                    end
                    default: begin
                        state_d = SEG_EMPTY;
                    end
                endcase
                if (flush_i) begin
                    state_d = SEG_EMPTY;
                    main_d  = RST_VAL;
                    skid_d  = RST_VAL;
                end
            end

            // State and payload registers; reset loads the bubble encoding.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    state_q <= SEG_EMPTY;
                    main_p0 <= RST_VAL;
                    skid_p1 <= RST_VAL;
                end else begin
                    state_q <= state_d;
                    main_p0 <= main_d;
                    skid_p1 <= skid_d;
                end
            end

            // in_ready comes straight from the state register to cut the path.
            assign in_ready  = (state_q != SEG_SKID);
            assign out_valid = (state_q != SEG_EMPTY);
            assign out_data  = main_p0;
            assign occupancy = seg_occ(state_q);
        end else begin : g_single
            logic              vld_p0;
            logic [DATA_W-1:0] main_p0;

            // Single entry: load on input fire, release on output fire.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    vld_p0  <= 1'b0;
                    main_p0 <= RST_VAL;
                end else if (flush_i) begin
                    vld_p0  <= 1'b0;
                    main_p0 <= RST_VAL;
                end else if (in_fire) begin
                    vld_p0  <= 1'b1;
                    main_p0 <= in_data;
                end else if (out_fire) begin
                    vld_p0  <= 1'b0;
                end
            end

            // Accept when empty or when the held entry leaves this cycle.
            assign in_ready  = !vld_p0 || out_ready;
            assign out_valid = vld_p0;
            assign out_data  = main_p0;
            assign occupancy = {1'b0, vld_p0};
        end
    endgenerate

    sat_cnt_ysyx_23060136 #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_seg_skid_reg_ysyx_23060136.sv
// Bench for the segment register: a skid-mode and a single-entry instance
// share one stimulus stream and are each checked against a queue model.
module tb_seg_skid_reg_ysyx_23060136;

    localparam int          DW   = 16;
    localparam logic [15:0] RV0  = 16'hDEAD;
    localparam logic [15:0] RV1  = 16'hBEEF;
    localparam int          CW0  = 3;
    localparam int          CW1  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [DW-1:0] out_data0, out_data1;
    logic [1:0]    occ0, occ1;
    logic [CW0-1:0] stall0;
    logic [CW1-1:0] stall1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: FIFO contents, last value shown, stall count.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] last0, last1;
    int            cnt0, cnt1;

    always #5 clk = ~clk;

    seg_skid_reg_ysyx_23060136 #(
        .DATA_W (DW), .RST_VAL (RV0), .SKID (1'b1), .CNT_W (CW0)
    ) u_dut0 (
        .clk (clk), .rst (rst), .flush_i (flush_i),
        .in_valid (in_valid), .in_ready (in_ready0), .in_data (in_data),
        .out_valid (out_valid0), .out_ready (out_ready), .out_data (out_data0),
        .occupancy (occ0), .stall_cnt (stall0)
    );

    seg_skid_reg_ysyx_23060136 #(
        .DATA_W (DW), .RST_VAL (RV1), .SKID (1'b0), .CNT_W (CW1)
    ) u_dut1 (
        .clk (clk), .rst (rst), .flush_i (flush_i),
        .in_valid (in_valid), .in_ready (in_ready1), .in_data (in_data),
        .out_valid (out_valid1), .out_ready (out_ready), .out_data (out_data1),
        .occupancy (occ1), .stall_cnt (stall1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output of both instances against the reference.
    task automatic check_all();
        chk("d0_out_valid", 32'(out_valid0), 32'(q0.size() != 0));
        chk("d0_in_ready",  32'(in_ready0),  32'(q0.size() < 2));
        chk("d0_occ",       32'(occ0),       32'(q0.size()));
        chk("d0_out_data",  32'(out_data0),  32'((q0.size() != 0) ? q0[0] : last0));
        chk("d0_stall",     32'(stall0),     32'(cnt0));
        chk("d1_out_valid", 32'(out_valid1), 32'(q1.size() != 0));
        chk("d1_in_ready",  32'(in_ready1),  32'(q1.size() == 0 || out_ready));
        chk("d1_occ",       32'(occ1),       32'(q1.size()));
        chk("d1_out_data",  32'(out_data1),  32'((q1.size() != 0) ? q1[0] : last1));
        chk("d1_stall",     32'(stall1),     32'(cnt1));
    endtask

    // Advance the reference by one clock edge using the current inputs.
    task automatic model_update();
        bit ov, ir;
        if (!rst) begin
            q0.delete(); q1.delete();
            last0 = RV0; last1 = RV1;
            cnt0 = 0; cnt1 = 0;
        end else begin
            ov = (q0.size() != 0);
            ir = (q0.size() < 2);
            if (ov && !out_ready && cnt0 < (1 << CW0) - 1) cnt0++;
            if (flush_i) begin
                q0.delete(); last0 = RV0;
            end else begin
                if (ov && out_ready) last0 = q0.pop_front();
                if (in_valid && ir) q0.push_back(in_data);
            end
            ov = (q1.size() != 0);
            ir = (q1.size() == 0) || out_ready;
            if (ov && !out_ready && cnt1 < (1 << CW1) - 1) cnt1++;
            if (flush_i) begin
                q1.delete(); last1 = RV1;
            end else begin
                if (ov && out_ready) last1 = q1.pop_front();
                if (in_valid && ir) q1.push_back(in_data);
            end
        end
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy,
                        input logic fl, input logic r);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush_i   = fl;
        rst       = r;
        #1;
        check_all();
        model_update();
        @(posedge clk);
    endtask

    initial begin
        last0 = RV0; last1 = RV1; cnt0 = 0; cnt1 = 0;

        // Reset held two cycles while upstream offers data.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0055; rst = 1'b0;
        model_update();
        @(posedge clk);
        step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_out_valid0", 32'(out_valid0), 32'd0);
        chk("rst_occ0",       32'(occ0),       32'd0);
        chk("rst_in_ready0",  32'(in_ready0),  32'd1);
        chk("rst_out_data0",  32'(out_data0),  32'(RV0));
        chk("rst_stall0",     32'(stall0),     32'd0);
        chk("rst_in_ready1",  32'(in_ready1),  32'd1);
        chk("rst_out_data1",  32'(out_data1),  32'(RV1));

        // Streaming 1..8 with the output always ready.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        // Skid fill: A and B taken, C held off.
        step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h000C, 1'b0, 1'b0, 1'b1);
        #1;
        chk("fill_occ0",      32'(occ0),      32'd2);
        chk("fill_in_ready0", 32'(in_ready0), 32'd0);
        chk("fill_head0",     32'(out_data0), 32'h000A);
        step(1'b1, 16'h000C, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h000C, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Flush while in SKID with a concurrent output fire.
        step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        #1;
        chk("flush_occ0",  32'(occ0),      32'd0);
        chk("flush_data0", 32'(out_data0), 32'(RV0));
        // Flush with a concurrent input fire drops the input.
        step(1'b1, 16'h0077, 1'b0, 1'b1, 1'b1);
        #1;
        chk("flush_in_drop0", 32'(out_valid0), 32'd0);
        chk("flush_in_drop1", 32'(out_valid1), 32'd0);

        // Stall counter saturation, survival across flush, clear on reset.
        step(1'b1, 16'h00D0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("stall_sat0", 32'(stall0), 32'd7);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("stall_flush0", 32'(stall0), 32'd7);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stall_rst0", 32'(stall0), 32'd0);

        // Single-entry: in_ready follows out_ready combinationally while full.
        step(1'b1, 16'h00E0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
        #1;
        chk("single_rdy_lo", 32'(in_ready1), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("single_rdy_hi", 32'(in_ready1), 32'd1);
        out_ready = 1'b0;
        #1;
        chk("single_rdy_lo2", 32'(in_ready1), 32'd0);
        check_all();
        model_update();
        @(posedge clk);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), DW'($urandom),
                 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 99) != 0));
        end
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
